// File: rtl/chess_clock_top.sv
// Two-player MM:SS chess clock with 1 Hz BCD countdown and 8-digit multiplexed 7-segment scan.
// Button edges act within 3 CLK cycles; display outputs are registered; no backpressure.
module chess_clock_top #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int REFRESH_DIV = 100_000,
  parameter int INIT_MIN    = 5
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic       SELECT,
  input  logic       STOP,
  input  logic       Set_Impulse,
  input  logic       D1,
  input  logic       D2,
  input  logic       D3,
  input  logic       D4,
  input  logic       D5,
  input  logic       D6,
  input  logic       D7,
  input  logic       D8,
  output logic [6:0] seg_out,
  output logic [7:0] seg_select
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [TW-1:0] TICK_MAX    = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [15:0]   INIT_TIME   = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10), 8'h00};

  // Time words are packed BCD {min tens, min units, sec tens, sec units}.
  function automatic logic [15:0] dec_time(input logic [15:0] t);
    logic [3:0] su, st, mu, mt;
    {mt, mu, st, su} = t;
    if (t != 16'h0000) begin
      if (su != 4'd0) su = su - 4'd1;
      else begin
        su = 4'd9;
        if (st != 4'd0) st = st - 4'd1;
        else begin
          st = 4'd5;
          if (mu != 4'd0) mu = mu - 4'd1;
          else begin
            mu = 4'd9;
            mt = mt - 4'd1;
          end
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  function automatic logic [3:0] bump(input logic [3:0] v, input logic [3:0] top);
    return (v >= top) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [15:0] inc_time(input logic [15:0] t, input logic [3:0] m);
    logic [3:0] su, st, mu, mt;
    {mt, mu, st, su} = t;
    if (m[0]) su = bump(su, 4'd9);
    if (m[1]) st = bump(st, 4'd5);
    if (m[2]) mu = bump(mu, 4'd9);
    if (m[3]) mt = bump(mt, 4'd9);
    return {mt, mu, st, su};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  logic [10:0] raw_in, sync1, sync2;
  logic [8:0]  prev;
  logic        stop_s, set_s, sel_rise;
  logic [7:0]  d_rise;

  assign raw_in   = {SELECT, STOP, Set_Impulse, D8, D7, D6, D5, D4, D3, D2, D1};
  assign stop_s   = sync2[9];
  assign set_s    = sync2[8];
  assign sel_rise = sync2[10] & ~prev[8];
  assign d_rise   = sync2[7:0] & ~prev[7:0];

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      prev  <= {sync2[10], sync2[7:0]};
    end
  end

  logic [15:0]   time_a, time_b;
  logic          active_b;
  logic [TW-1:0] tick_cnt;
  logic          tick_wrap;

  assign tick_wrap = (tick_cnt == TICK_MAX);

  // Setting mode and countdown are mutually exclusive since both hinge on STOP.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      time_a   <= INIT_TIME;
      time_b   <= INIT_TIME;
      active_b <= 1'b0;
      tick_cnt <= '0;
    end else if (stop_s) begin
      if (set_s) begin
        time_a <= inc_time(time_a, d_rise[3:0]);
        time_b <= inc_time(time_b, d_rise[7:4]);
      end
    end else if (sel_rise) begin
      active_b <= ~active_b;
      tick_cnt <= '0;
    end else if (CE) begin
      if (tick_wrap) begin
        tick_cnt <= '0;
        if (active_b) time_b <= dec_time(time_b);
        else          time_a <= dec_time(time_a);
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  logic [RW-1:0] ref_cnt;
  logic [2:0]    idx, idx_nxt;
  logic [31:0]   digits;
  logic [3:0]    digit_nxt;

  assign digits    = {time_b, time_a};
  assign idx_nxt   = idx + 3'd1;
  assign digit_nxt = digits[{idx_nxt, 2'b00} +: 4];

  // idx resets to 7 so the first refresh wrap lands on digit 0.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      ref_cnt    <= '0;
      idx        <= 3'd7;
      seg_select <= 8'hFF;
      seg_out    <= 7'h7F;
    end else if (ref_cnt == REFRESH_MAX) begin
      ref_cnt    <= '0;
      idx        <= idx_nxt;
      seg_select <= ~(8'd1 << idx_nxt);
      seg_out    <= seg7(digit_nxt);
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_chess_clock_top.sv
// Directed bench for chess_clock_top; times are recovered by decoding the multiplexed display.
module tb_chess_clock_top;

  logic       clk = 1'b0;
  logic       clr, ce, select, stop, set_imp;
  logic [8:1] d;
  logic [6:0] seg_out;
  logic [7:0] seg_select;

  int n_chk  = 0;
  int n_fail = 0;

  chess_clock_top #(.TICK_DIV(4), .REFRESH_DIV(2), .INIT_MIN(5)) dut (
    .CLK(clk), .CLR(clr), .CE(ce), .SELECT(select), .STOP(stop), .Set_Impulse(set_imp),
    .D1(d[1]), .D2(d[2]), .D3(d[3]), .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]), .D8(d[8]),
    .seg_out(seg_out), .seg_select(seg_select)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sel;
    logic [6:0] seg;
  } scan_vec_t;

  typedef struct {
    logic [8:1]  dmask;
    logic        stop;
    logic        set_imp;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } set_vec_t;

  scan_vec_t scan_vecs[8];
  set_vec_t  set_vecs[12];

  function automatic logic [3:0] seg2dig(input logic [6:0] s);
    case (s)
      7'h40:   return 4'd0;
      7'h79:   return 4'd1;
      7'h24:   return 4'd2;
      7'h30:   return 4'd3;
      7'h19:   return 4'd4;
      7'h12:   return 4'd5;
      7'h02:   return 4'd6;
      7'h78:   return 4'd7;
      7'h00:   return 4'd8;
      7'h10:   return 4'd9;
      default: return 4'hF;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_ce(input int n);
    ce = 1'b1;
    cyc(n);
    ce = 1'b0;
  endtask

  task automatic pulse_d(input logic [8:1] m);
    d = m;
    cyc(4);
    d = '0;
    cyc(4);
  endtask

  task automatic pulse_select();
    select = 1'b1;
    cyc(4);
    select = 1'b0;
    cyc(4);
  endtask

  // Waits for a fresh scan pass, then collects all eight digits (bounded).
  task automatic read_check(input string name, input logic [15:0] exp_a, input logic [15:0] exp_b);
    logic [31:0] all;
    logic [7:0]  seen;
    all  = '1;
    seen = '0;
    cyc(20);
    for (int i = 0; i < 60 && seen != 8'hFF; i++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++)
        if (seg_select == ~(8'd1 << k)) begin
          all[k*4 +: 4] = seg2dig(seg_out);
          seen[k] = 1'b1;
        end
    end
    chk({name, "_scan_seen"}, {8'h00, seen}, 16'h00FF);
    chk({name, "_A"}, all[15:0], exp_a);
    chk({name, "_B"}, all[31:16], exp_b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    scan_vecs[0] = '{8'hFE, 7'h40};
    scan_vecs[1] = '{8'hFD, 7'h40};
    scan_vecs[2] = '{8'hFB, 7'h12};
    scan_vecs[3] = '{8'hF7, 7'h40};
    scan_vecs[4] = '{8'hEF, 7'h40};
    scan_vecs[5] = '{8'hDF, 7'h40};
    scan_vecs[6] = '{8'hBF, 7'h12};
    scan_vecs[7] = '{8'h7F, 7'h40};

    set_vecs[0]  = '{8'h01, 1'b1, 1'b1, 16'h0001, 16'h0000};
    set_vecs[1]  = '{8'h02, 1'b1, 1'b1, 16'h0011, 16'h0000};
    set_vecs[2]  = '{8'h04, 1'b1, 1'b1, 16'h0111, 16'h0000};
    set_vecs[3]  = '{8'h08, 1'b1, 1'b1, 16'h1111, 16'h0000};
    set_vecs[4]  = '{8'h10, 1'b1, 1'b1, 16'h1111, 16'h0001};
    set_vecs[5]  = '{8'h20, 1'b1, 1'b1, 16'h1111, 16'h0011};
    set_vecs[6]  = '{8'h40, 1'b1, 1'b1, 16'h1111, 16'h0111};
    set_vecs[7]  = '{8'h80, 1'b1, 1'b1, 16'h1111, 16'h1111};
    set_vecs[8]  = '{8'h11, 1'b1, 1'b0, 16'h1111, 16'h1111};
    set_vecs[9]  = '{8'h08, 1'b0, 1'b1, 16'h1111, 16'h1111};
    set_vecs[10] = '{8'h11, 1'b1, 1'b1, 16'h1112, 16'h1112};
    set_vecs[11] = '{8'h22, 1'b1, 1'b1, 16'h1122, 16'h1122};

    clr = 1'b0; ce = 1'b0; select = 1'b0; stop = 1'b0; set_imp = 1'b0; d = '0;
    cyc(3);
    chk("reset_seg_select", {8'h00, seg_select}, 16'h00FF);
    chk("reset_seg_out", {9'h000, seg_out}, 16'h007F);

    // Scan from reset: still blank one cycle after release, then digit 0 every 2 cycles.
    clr = 1'b1;
    cyc(1);
    chk("scan_pre_wrap_sel", {8'h00, seg_select}, 16'h00FF);
    cyc(1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc(2);
      chk($sformatf("scan_sel_%0d", k), {8'h00, seg_select}, {8'h00, scan_vecs[k].sel});
      chk($sformatf("scan_seg_%0d", k), {9'h000, seg_out}, {9'h000, scan_vecs[k].seg});
    end
    cyc(2);
    chk("scan_wrap_sel", {8'h00, seg_select}, 16'h00FE);

    read_check("reset_times", 16'h0500, 16'h0500);

    run_ce(16);
    read_check("countdown_4", 16'h0456, 16'h0500);
    cyc(20);
    read_check("ce_low_hold", 16'h0456, 16'h0500);

    pulse_select();
    run_ce(8);
    read_check("switch_to_b", 16'h0456, 16'h0458);

    stop = 1'b1;
    cyc(4);
    pulse_select();
    stop = 1'b0;
    cyc(4);
    run_ce(4);
    read_check("select_while_stop", 16'h0456, 16'h0457);

    // Load A to 00:01 from 04:56, then switch back to A and time out.
    stop = 1'b1; set_imp = 1'b1;
    cyc(4);
    for (int i = 0; i < 5; i++) pulse_d(8'h01);
    pulse_d(8'h02);
    for (int i = 0; i < 6; i++) pulse_d(8'h04);
    read_check("load_a_0001", 16'h0001, 16'h0457);
    stop = 1'b0; set_imp = 1'b0;
    cyc(4);
    pulse_select();
    run_ce(4);
    read_check("timeout_reach", 16'h0000, 16'h0457);
    run_ce(12);
    read_check("timeout_hold", 16'h0000, 16'h0457);

    stop = 1'b1; set_imp = 1'b1;
    cyc(4);
    for (int i = 0; i < 3; i++) pulse_d(8'h10);
    pulse_d(8'h20);
    for (int i = 0; i < 6; i++) pulse_d(8'h40);
    read_check("zero_b", 16'h0000, 16'h0000);
    for (int i = 0; i < 6; i++) pulse_d(8'h02);
    read_check("sec_tens_wrap", 16'h0000, 16'h0000);

    for (int v = 0; v < 12; v++) begin
      stop    = set_vecs[v].stop;
      set_imp = set_vecs[v].set_imp;
      cyc(4);
      pulse_d(set_vecs[v].dmask);
      read_check($sformatf("set_vec_%0d", v), set_vecs[v].exp_a, set_vecs[v].exp_b);
    end

    // A D level held high increments only once.
    d = 8'h04;
    cyc(30);
    d = '0;
    cyc(4);
    read_check("d_held_high", 16'h1222, 16'h1122);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
